// File: rtl/nes_mem_pkg.sv
// Shared definitions for the NES CPU-bus memory responder.
//   region_t    : which block an address lands in
//   *_BASE      : first address of each region in the 6502 map
//   DMA_ADDR    : OAM DMA trigger register
//   dma_state_t : OAM DMA sequencer states
package nes_mem_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_IO,
        REG_UNMAP,
        REG_SRAM,
        REG_ROM
    } region_t;

    localparam logic [15:0] RAM_BASE   = 16'h0000;
    localparam logic [15:0] IO_BASE    = 16'h2000;
    localparam logic [15:0] UNMAP_BASE = 16'h4000;
    localparam logic [15:0] SRAM_BASE  = 16'h6000;
    localparam logic [15:0] ROM_BASE   = 16'h8000;

    localparam logic [15:0] DMA_ADDR   = 16'h4014;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RD,
        WR
    } dma_state_t;

endpackage

// File: rtl/nes_addr_decode.sv
// Combinational CPU-bus address decoder.
//   addr_i   : 16-bit bus address
//   region_o : region the address falls in
//   idx_o    : index local to that region (mirroring already applied by
//              dropping the upper bits; 0 for unmapped addresses)
module nes_addr_decode
    import nes_mem_pkg::*;
#(
    parameter int RAM_AW  = 11,
    parameter int IO_AW   = 3,
    parameter int SRAM_AW = 13,
    parameter int ROM_AW  = 15
) (
    input  logic [15:0]       addr_i,
    output region_t           region_o,
    output logic [ROM_AW-1:0] idx_o
);

    always_comb begin
        region_o = REG_UNMAP;
        idx_o    = '0;
        if (addr_i >= RAM_BASE && addr_i < IO_BASE) begin
            region_o            = REG_RAM;
            idx_o[RAM_AW-1:0]   = addr_i[RAM_AW-1:0];
        end else if (addr_i < UNMAP_BASE) begin
            region_o            = REG_IO;
            idx_o[IO_AW-1:0]    = addr_i[IO_AW-1:0];
        end else if (addr_i < SRAM_BASE) begin
            region_o            = REG_UNMAP;
        end else if (addr_i < ROM_BASE) begin
            region_o            = REG_SRAM;
            idx_o[SRAM_AW-1:0]  = addr_i[SRAM_AW-1:0];
        end else begin
            region_o            = REG_ROM;
            idx_o               = addr_i[ROM_AW-1:0];
        end
    end

endmodule

// File: rtl/nes_cpu_mem_responder.sv
// Memory side of the 6502 CPU bus: internal RAM, cartridge SRAM, a small
// I/O register file and PRG ROM, plus the $4014 OAM DMA engine.
//   clk, b_rst        : clock, async active-low reset
//   cpu_addr_out/cpu_data_out/ren/wen : CPU bus request
//   cpu_data_in       : registered read data (1-cycle latency, held)
//   rdy               : low while DMA owns the bus
//   rom_we/rom_addr/rom_data : loader port into PRG ROM
//   oam_we/oam_idx/oam_data  : registered per-byte DMA strobe to OAM
module nes_cpu_mem_responder #(
    parameter int          RAM_AW     = 11,
    parameter int          SRAM_AW    = 13,
    parameter int          ROM_AW     = 15,
    parameter int          IO_AW      = 3,
    parameter logic [15:0] DMA_ADDR   = nes_mem_pkg::DMA_ADDR,
    parameter int          OAM_IO_IDX = 4
) (
    input  logic              clk,
    input  logic              b_rst,
    input  logic [15:0]       cpu_addr_out,
    input  logic [7:0]        cpu_data_out,
    input  logic              ren,
    input  logic              wen,
    output logic [7:0]        cpu_data_in,
    output logic              rdy,
    input  logic              rom_we,
    input  logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              oam_we,
    output logic [7:0]        oam_idx,
    output logic [7:0]        oam_data
);

    import nes_mem_pkg::*;

    // Storage that is never cleared by reset.
    logic [7:0] ram_mem  [2**RAM_AW];
    logic [7:0] sram_mem [2**SRAM_AW];
    logic [7:0] rom_mem  [2**ROM_AW];

    logic [7:0] io_q [2**IO_AW];
    logic [7:0] io_d [2**IO_AW];

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] cpu_data_q, cpu_data_d;
    logic       oam_we_q, oam_we_d;
    logic [7:0] oam_idx_q, oam_idx_d;
    logic [7:0] oam_data_q, oam_data_d;

    logic cpu_rd, cpu_wr;

    // The CPU owns the bus only while the DMA engine is idle.
    assign rdy    = (state_q == IDLE);
    // A simultaneous read+write performs the write and leaves read data alone.
    assign cpu_rd = rdy && ren && !wen;
    assign cpu_wr = rdy && wen;

    region_t           cpu_region, dma_region;
    logic [ROM_AW-1:0] cpu_idx, dma_idx;
    logic [15:0]       dma_addr;

    assign dma_addr = {page_q, cnt_q};

    nes_addr_decode #(
        .RAM_AW (RAM_AW),
        .IO_AW  (IO_AW),
        .SRAM_AW(SRAM_AW),
        .ROM_AW (ROM_AW)
    ) u_cpu_dec (
        .addr_i  (cpu_addr_out),
        .region_o(cpu_region),
        .idx_o   (cpu_idx)
    );

    nes_addr_decode #(
        .RAM_AW (RAM_AW),
        .IO_AW  (IO_AW),
        .SRAM_AW(SRAM_AW),
        .ROM_AW (ROM_AW)
    ) u_dma_dec (
        .addr_i  (dma_addr),
        .region_o(dma_region),
        .idx_o   (dma_idx)
    );

    // Read muxes: one per bus master, same map.
    logic [7:0] cpu_rd_data, dma_rd_data;

    always_comb begin
        cpu_rd_data = 8'h00;
        case (cpu_region)
            REG_RAM:  cpu_rd_data = ram_mem[cpu_idx[RAM_AW-1:0]];
            REG_IO:   cpu_rd_data = io_q[cpu_idx[IO_AW-1:0]];
            REG_SRAM: cpu_rd_data = sram_mem[cpu_idx[SRAM_AW-1:0]];
            REG_ROM:  cpu_rd_data = rom_mem[cpu_idx];
            default:  cpu_rd_data = 8'h00;
        endcase
    end

    always_comb begin
        dma_rd_data = 8'h00;
        case (dma_region)
            REG_RAM:  dma_rd_data = ram_mem[dma_idx[RAM_AW-1:0]];
            REG_IO:   dma_rd_data = io_q[dma_idx[IO_AW-1:0]];
            REG_SRAM: dma_rd_data = sram_mem[dma_idx[SRAM_AW-1:0]];
            REG_ROM:  dma_rd_data = rom_mem[dma_idx];
            default:  dma_rd_data = 8'h00;
        endcase
    end

    // Memory writes. ROM is written only by the loader port.
    always_ff @(posedge clk) begin
        if (cpu_wr && cpu_region == REG_RAM)
            ram_mem[cpu_idx[RAM_AW-1:0]] <= cpu_data_out;
        if (cpu_wr && cpu_region == REG_SRAM)
            sram_mem[cpu_idx[SRAM_AW-1:0]] <= cpu_data_out;
        if (rom_we)
            rom_mem[rom_addr] <= rom_data;
    end

    // CPU access plus DMA sequencer. CPU writes only happen in IDLE, so they
    // never collide with the DMA write into the OAM I/O register.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        cpu_data_d = cpu_data_q;
        oam_we_d   = 1'b0;
        oam_idx_d  = oam_idx_q;
        oam_data_d = oam_data_q;
        for (int i = 0; i < 2**IO_AW; i++)
            io_d[i] = io_q[i];

        if (cpu_rd)
            cpu_data_d = cpu_rd_data;
        if (cpu_wr && cpu_region == REG_IO)
            io_d[cpu_idx[IO_AW-1:0]] = cpu_data_out;

        case (state_q)
            IDLE: begin
                if (cpu_wr && cpu_addr_out == DMA_ADDR) begin
                    page_d  = cpu_data_out;
                    cnt_d   = 8'h00;
                    state_d = START;
                end
            end
            START: state_d = RD;
            RD: begin
                byte_d  = dma_rd_data;
                state_d = WR;
            end
            WR: begin
                io_d[OAM_IO_IDX] = byte_q;
                oam_we_d         = 1'b1;
                oam_idx_d        = cnt_q;
                oam_data_d       = byte_q;
                cnt_d            = cnt_q + 8'd1;
                // Byte 255 is the last one; the counter wrap ends the transfer.
                state_d          = (cnt_q == 8'hFF) ? IDLE : RD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state_q    <= IDLE;
            page_q     <= 8'h00;
            cnt_q      <= 8'h00;
            byte_q     <= 8'h00;
            cpu_data_q <= 8'h00;
            oam_we_q   <= 1'b0;
            oam_idx_q  <= 8'h00;
            oam_data_q <= 8'h00;
            for (int i = 0; i < 2**IO_AW; i++)
                io_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            cpu_data_q <= cpu_data_d;
            oam_we_q   <= oam_we_d;
            oam_idx_q  <= oam_idx_d;
            oam_data_q <= oam_data_d;
            for (int i = 0; i < 2**IO_AW; i++)
                io_q[i] <= io_d[i];
        end
    end

    assign cpu_data_in = cpu_data_q;
    assign oam_we      = oam_we_q;
    assign oam_idx     = oam_idx_q;
    assign oam_data    = oam_data_q;

endmodule

// File: tb/tb_nes_cpu_mem_responder.sv
// Directed bench for nes_cpu_mem_responder: map decode, mirroring, read
// latency, ignored writes, OAM DMA from several regions and reset mid-DMA.
module tb_nes_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        b_rst = 1'b0;
    logic [15:0] cpu_addr_out = 16'h0000;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  cpu_data_in;
    logic        rdy;
    logic        rom_we = 1'b0;
    logic [14:0] rom_addr = 15'h0000;
    logic [7:0]  rom_data = 8'h00;
    logic        oam_we;
    logic [7:0]  oam_idx;
    logic [7:0]  oam_data;

    int n_chk  = 0;
    int n_pass = 0;

    nes_cpu_mem_responder dut (
        .clk         (clk),
        .b_rst       (b_rst),
        .cpu_addr_out(cpu_addr_out),
        .cpu_data_out(cpu_data_out),
        .ren         (ren),
        .wen         (wen),
        .cpu_data_in (cpu_data_in),
        .rdy         (rdy),
        .rom_we      (rom_we),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .oam_we      (oam_we),
        .oam_idx     (oam_idx),
        .oam_data    (oam_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr_out = a; cpu_data_out = d; wen = 1'b1; ren = 1'b0;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] e);
        @(negedge clk);
        cpu_addr_out = a; ren = 1'b1; wen = 1'b0;
        @(negedge clk);
        ren = 1'b0;
        check(tag, cpu_data_in, e);
    endtask

    // 0: RAM pattern i^3C, 1: SRAM pattern i*7+1, 2: unmapped (zero)
    function automatic logic [7:0] exp_byte(input int kind, input int i);
        int v;
        v = i * 7 + 1;
        case (kind)
            0:       return i[7:0] ^ 8'h3C;
            1:       return v[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic run_dma(input string tag, input logic [7:0] page, input int kind,
                           input logic [7:0] hold);
        int   low = 0;
        int   pulses = 0;
        int   b2b = 0;
        logic prev = 1'b0;
        @(negedge clk);
        cpu_addr_out = 16'h4014; cpu_data_out = page; wen = 1'b1; ren = 1'b0;
        @(negedge clk);
        // A read held throughout the transfer must be ignored.
        wen = 1'b0; ren = 1'b1; cpu_addr_out = 16'h0012;
        for (int c = 0; c < 700; c++) begin
            if (oam_we) begin
                check({tag, " idx/data"}, {oam_idx, oam_data},
                      {pulses[7:0], exp_byte(kind, pulses)});
                if (prev) b2b++;
                pulses++;
            end
            prev = oam_we;
            if (rdy) break;
            low++;
            @(negedge clk);
        end
        ren = 1'b0;
        check({tag, " rdy_low_cycles"}, low, 513);
        check({tag, " pulses"}, pulses, 256);
        check({tag, " back_to_back"}, b2b, 0);
        check({tag, " rdy_after"}, rdy, 1'b1);
        check({tag, " data_held"}, cpu_data_in, hold);
    endtask

    initial begin
        int pulses;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst rdy", rdy, 1'b1);
        check("rst cpu_data_in", cpu_data_in, 8'h00);
        check("rst oam_we", oam_we, 1'b0);
        check("rst oam_idx", oam_idx, 8'h00);
        check("rst oam_data", oam_data, 8'h00);
        b_rst = 1'b1;

        // ROM preload and 1-cycle read latency
        @(negedge clk);
        rom_we = 1'b1; rom_addr = 15'h0000; rom_data = 8'hA9;
        @(negedge clk);
        rom_we = 1'b0;
        check("pre-read cpu_data_in", cpu_data_in, 8'h00);
        check("pre-read rdy", rdy, 1'b1);
        cpu_addr_out = 16'h8000; ren = 1'b1;
        @(posedge clk); #1;
        check("rom read latency", cpu_data_in, 8'hA9);
        @(negedge clk);
        ren = 1'b0;
        @(negedge clk);
        check("rom read held", cpu_data_in, 8'hA9);

        // RAM and I/O mirroring
        cpu_write(16'h0012, 8'h5C);
        rd_chk("ram mirror 0812", 16'h0812, 8'h5C);
        rd_chk("ram mirror 1012", 16'h1012, 8'h5C);
        rd_chk("ram mirror 1812", 16'h1812, 8'h5C);
        cpu_write(16'h2003, 8'h77);
        rd_chk("io mirror 3FFB", 16'h3FFB, 8'h77);

        // Ignored writes, unmapped reads
        cpu_write(16'h8000, 8'hFF);
        rd_chk("rom write ignored", 16'h8000, 8'hA9);
        rd_chk("unmapped read", 16'h5000, 8'h00);

        // ren+wen together: write lands, read data unchanged
        rd_chk("ram 0012", 16'h0012, 8'h5C);
        @(negedge clk);
        cpu_addr_out = 16'h0000; cpu_data_out = 8'h11; ren = 1'b1; wen = 1'b1;
        @(negedge clk);
        ren = 1'b0; wen = 1'b0;
        check("ren+wen data held", cpu_data_in, 8'h5C);
        rd_chk("ren+wen write done", 16'h0000, 8'h11);

        // Read directly after write, no idle cycle
        @(negedge clk);
        cpu_addr_out = 16'h0100; cpu_data_out = 8'h42; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        check("read after write", cpu_data_in, 8'h42);

        // DMA from RAM page $02
        for (int i = 0; i < 256; i++) cpu_write(16'h0200 + 16'(i), exp_byte(0, i));
        run_dma("dma_ram", 8'h02, 0, 8'h42);
        rd_chk("io4 after dma_ram", 16'h2004, 8'hC3);
        rd_chk("io4 mirror after dma_ram", 16'h3FFC, 8'hC3);

        // Reset in the middle of a transfer
        @(negedge clk);
        cpu_addr_out = 16'h4014; cpu_data_out = 8'h02; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        pulses = 0;
        for (int c = 0; c < 400; c++) begin
            if (oam_we) pulses++;
            if (pulses == 100) break;
            @(negedge clk);
        end
        check("pulses before reset", pulses, 100);
        b_rst = 1'b0;
        #1;
        check("mid-dma rst rdy", rdy, 1'b1);
        check("mid-dma rst oam_we", oam_we, 1'b0);
        check("mid-dma rst oam_idx", oam_idx, 8'h00);
        check("mid-dma rst cpu_data_in", cpu_data_in, 8'h00);
        repeat (3) @(negedge clk);
        b_rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (oam_we) pulses++;
        end
        check("no oam_we after reset", pulses, 0);
        check("rdy after reset", rdy, 1'b1);
        rd_chk("io3 cleared", 16'h2003, 8'h00);
        rd_chk("io4 cleared", 16'h2004, 8'h00);
        rd_chk("ram kept", 16'h0012, 8'h5C);
        rd_chk("rom kept", 16'h8000, 8'hA9);

        // DMA from SRAM page $60 (also checks restart from index 0)
        for (int i = 0; i < 256; i++) cpu_write(16'h6000 + 16'(i), exp_byte(1, i));
        run_dma("dma_sram", 8'h60, 1, 8'hA9);
        rd_chk("io4 after dma_sram", 16'h2004, 8'hFA);

        // DMA from unmapped page $40
        run_dma("dma_unmap", 8'h40, 2, 8'hFA);
        rd_chk("io4 after dma_unmap", 16'h2004, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
